// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single data-memory port
// Optional: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 always wins ties).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  req0,
    input  logic                  write0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  owner_q;
    logic                  write_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  grant_valid_d;
    logic                  grant_port_d;
    logic                  grant_write_d;
    logic [ADDR_WIDTH-1:0] grant_addr_d;
    logic [DATA_WIDTH-1:0] grant_wdata_d;

    // Arbitration decision; only acted upon while IDLE.
    always_comb begin
        grant_valid_d = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        grant_port_d  = !req0;
`else
        grant_port_d  = (req0 && req1) ? !last_grant_q : req1;
`endif
        grant_write_d = grant_port_d ? write1 : write0;
        grant_addr_d  = grant_port_d ? addr1  : addr0;
        grant_wdata_d = grant_port_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        owner_q     <= grant_port_d;
                        write_q     <= grant_write_d;
                        mem_addr_q  <= grant_addr_d;
                        mem_wdata_q <= grant_wdata_d;
                        mem_write_q <= grant_write_d;
                        mem_read_q  <= !grant_write_d;
                        ack0_q      <= !grant_port_d;
                        ack1_q      <= grant_port_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_grant_q <= owner_q;
                    if (write_q) begin
                        state_q <= IDLE;
                    end else begin
                        rvalid0_q <= !owner_q;
                        rvalid1_q <= owner_q;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (owner_q) begin
                        rdata1_q <= memRdata;
                    end else begin
                        rdata0_q <= memRdata;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data passes straight through to the owner during RDATA, then holds.
    assign rdata0   = (state_q == RDATA && !owner_q) ? memRdata : rdata0_q;
    assign rdata1   = (state_q == RDATA &&  owner_q) ? memRdata : rdata1_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    logic        clk;
    logic        resetN;
    logic        req0, write0, ack0, rvalid0;
    logic [63:0] addr0, wdata0, rdata0;
    logic        req1, write1, ack1, rvalid1;
    logic [63:0] addr1, wdata1, rdata1;
    logic        MemRead, MemWrite;
    logic [63:0] memAddr, memWdata, memRdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_m = 1;
    int ack_cyc = 0;
    logic [63:0] last_rd [2];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] dmem [logic [63:0]];
    logic [63:0] addr_tab [5];

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .resetN(resetN),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .MemRead(MemRead), .MemWrite(MemWrite), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: write on MemWrite, registered read data the cycle after MemRead.
    always @(posedge clk) begin
        if (MemWrite) dmem[memAddr] = memWdata;
        if (MemRead) memRdata <= dmem.exists(memAddr) ? dmem[memAddr] : 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int pick(input logic r0, input logic r1, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        return r0 ? 0 : 1;
`else
        if (r0 && r1) return 1 - last;
        return r0 ? 0 : 1;
`endif
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
    endfunction

    // One complete transaction starting from an IDLE cycle with requests driven; ends in IDLE.
    task automatic service();
        int          w;
        logic        wr;
        logic [63:0] a, d, e;
        w  = pick(req0, req1, last_m);
        wr = (w == 1) ? write1 : write0;
        a  = (w == 1) ? addr1  : addr0;
        d  = (w == 1) ? wdata1 : wdata0;
        step();
        chk("ack0", ack0, w == 0);
        chk("ack1", ack1, w == 1);
        chk("MemWrite", MemWrite, wr);
        chk("MemRead", MemRead, !wr);
        chk("memAddr", memAddr, a);
        if (wr) begin
            chk("memWdata", memWdata, d);
            ref_mem[a] = d;
        end
        last_m  = w;
        ack_cyc = cyc;
        if (!wr) begin
            step();
            e = ref_read(a);
            chk("rvalid0", rvalid0, w == 0);
            chk("rvalid1", rvalid1, w == 1);
            chk("rdata_owner", (w == 1) ? rdata1 : rdata0, e);
            chk("rdata_other", (w == 1) ? rdata0 : rdata1, last_rd[1 - w]);
            last_rd[w] = e;
        end
        step();
        chk("idle_strobes", {ack0, ack1, rvalid0, rvalid1, MemRead, MemWrite}, 64'd0);
    endtask

    task automatic zero_outputs(input string tag);
        chk(tag, {ack0, ack1, rvalid0, rvalid1, MemRead, MemWrite}, 64'd0);
        chk({tag, "_addr"}, memAddr, 64'd0);
        chk({tag, "_wdata"}, memWdata, 64'd0);
        chk({tag, "_rdata0"}, rdata0, 64'd0);
        chk({tag, "_rdata1"}, rdata1, 64'd0);
    endtask

    // Mid-cycle reset pulse; outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        #1 resetN = 1'b0;
        #1 zero_outputs("async_rst");
        @(posedge clk);
        #1 zero_outputs("held_rst");
        resetN     = 1'b1;
        last_m     = 1;
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
    endtask

    task automatic rand_cmd0();
        write0 = 1'($urandom_range(1, 0));
        addr0  = addr_tab[$urandom_range(4, 0)];
        wdata0 = {$urandom, $urandom};
    endtask

    task automatic rand_cmd1();
        write1 = 1'($urandom_range(1, 0));
        addr1  = addr_tab[$urandom_range(4, 0)];
        wdata1 = {$urandom, $urandom};
    endtask

    initial begin
        int prev;
        int w;
        addr_tab[0] = 64'h10;
        addr_tab[1] = 64'h18;
        addr_tab[2] = 64'h20;
        addr_tab[3] = 64'h28;
        addr_tab[4] = 64'hFFFF_FFFF_FFFF_FFF8;
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        resetN = 1'b0;
        req0 = 0; write0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; write1 = 0; addr1 = 0; wdata1 = 0;
        memRdata = 64'd0;

        step();
        step();
        zero_outputs("reset");
        resetN = 1'b1;

        // Port 0 write, then port 1 reads it back.
        req0 = 1; write0 = 1; addr0 = 64'h10; wdata0 = 64'hDEAD;
        service();
        req0 = 0;
        req1 = 1; write1 = 0; addr1 = 64'h10;
        service();
        req1 = 0;

        // Both held from reset: round-robin alternation (port 0 only in fixed mode).
        async_reset();
        req0 = 1; req1 = 1;
        rand_cmd0();
        rand_cmd1();
        for (int i = 0; i < 4; i++) begin
            w = pick(req0, req1, last_m);
            service();
            if (w == 0) rand_cmd0(); else rand_cmd1();
        end
        req0 = 0; req1 = 0;

        // Single requester held for three reads: ack every third cycle.
        req0 = 1; write0 = 0; addr0 = 64'h10;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            service();
            if (i > 0) chk("ack0_period", 64'(ack_cyc - prev), 64'd3);
            prev = ack_cyc;
            addr0 = addr_tab[i + 1];
        end
        req0 = 0;

        // Randomized traffic with withdrawals.
        for (int i = 0; i < 40; i++) begin
            if (!req0 && $urandom_range(1, 0) == 1) begin req0 = 1; rand_cmd0(); end
            if (!req1 && $urandom_range(1, 0) == 1) begin req1 = 1; rand_cmd1(); end
            if (!req0 && !req1) begin
                step();
                chk("no_req_idle", {ack0, ack1, MemRead, MemWrite}, 64'd0);
            end else begin
                w = pick(req0, req1, last_m);
                service();
                if (w == 0) begin
                    if ($urandom_range(1, 0) == 1) rand_cmd0(); else req0 = 0;
                    if ($urandom_range(3, 0) == 0) req1 = 0;
                end else begin
                    if ($urandom_range(1, 0) == 1) rand_cmd1(); else req1 = 0;
                    if ($urandom_range(3, 0) == 0) req0 = 0;
                end
            end
        end
        req0 = 0; req1 = 0;
        step();

        // Reset during RDATA of a port 1 read; a pending req0 wins afterwards.
        req1 = 1; write1 = 0; addr1 = 64'h10;
        step();
        chk("rst_rd_ack1", ack1, 64'd1);
        chk("rst_rd_memread", MemRead, 64'd1);
        req1 = 0;
        req0 = 1; write0 = 1; addr0 = 64'h28; wdata0 = {$urandom, $urandom};
        step();
        async_reset();
        req1 = 1; write1 = 0; addr1 = 64'h28;
        service();
        req0 = 0;
        service();
        req1 = 0;

        // Reset during ISSUE of a port 0 read; lastGrant must return to 1.
        req0 = 1; write0 = 0; addr0 = 64'h28;
        step();
        chk("rst_iss_ack0", ack0, 64'd1);
        async_reset();
        req1 = 1; write1 = 0; addr1 = 64'h10;
        service();
        req0 = 0;
        service();
        req1 = 0;

        // req1 pulsed only during port 0 ISSUE: never seen.
        req0 = 1; write0 = 1; addr0 = 64'h20; wdata0 = {$urandom, $urandom};
        step();
        chk("pulse_ack0", ack0, 64'd1);
        chk("pulse_memwrite", MemWrite, 64'd1);
        ref_mem[addr0] = wdata0;
        last_m = 0;
        req0 = 0;
        req1 = 1; write1 = 0; addr1 = 64'h20;
        step();
        chk("pulse_no_ack1_a", {ack1, MemRead}, 64'd0);
        req1 = 0;
        step();
        chk("pulse_no_ack1_b", {ack1, MemRead, MemWrite}, 64'd0);
        step();
        chk("pulse_no_rvalid1", {ack1, rvalid1, MemRead, MemWrite}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
